// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store sequencer between the core memory stage and a word-wide data
//   memory. Byte and halfword stores are done as read-modify-write. Loads
//   return sign- or zero-extended lane data. busy/done stall the core.
//
// Ports
//   clock, reset        rising-edge clock, async active-high reset
//   req, we, size,      access request (sampled in IDLE only), store flag,
//   ld_unsigned         size (00 b, 01 h, 10 w, 11 reserved), zero-extend
//   addr, wdata         byte address, right-justified store data
//   busy, done, err     state != IDLE, completion pulse, rejected access
//   rdata               last load result
//   mem_address         word index of the registered address
//   mem_write_data      word written during WR
//   mem_write, mem_read d_mem strobes
//   mem_read_data       d_mem read data (combinational from mem_address)
//
// state | meaning
// IDLE  | waiting for req
// RD    | reading target word (load, or first half of sub-word store)
// WR    | writing word or merged word
// DONE  | access complete, done pulse
// ERR   | access rejected, done + err pulse
module mem_access_unit #(
  parameter int ADDR_W          = 32,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              ld_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [31:0]       mem_read_data
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] WR   = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;

  logic              misalign;
  logic              reject;
  logic [ADDR_W-1:0] addr_al;

  function automatic logic [31:0] lane_extract(input logic [31:0] w,
                                               input logic [1:0]  a,
                                               input logic [1:0]  sz,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_B:    r = {{24{~uns & b[7]}}, b};
      SZ_H:    r = {{16{~uns & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] w,
                                             input logic [1:0]  a,
                                             input logic [1:0]  sz,
                                             input logic [31:0] d);
    logic [31:0] m;
    m = w;
    case (sz)
      SZ_B: m[{a, 3'b000} +: 8] = d[7:0];
      SZ_H: begin
        if (a[1]) m[31:16] = d[15:0];
        else      m[15:0]  = d[15:0];
      end
      default: m = d;
    endcase
    return m;
  endfunction

  // Reserved size is always rejected; real misalignment only when enabled.
  always_comb begin
    misalign = 1'b0;
    case (size)
      SZ_H:    misalign = addr[0];
      SZ_W:    misalign = (addr[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
    reject = (size == 2'b11) | (ERR_ON_MISALIGN & misalign);
  end

  // With rejection disabled, misaligned addresses snap down to the lane.
  always_comb begin
    addr_al = addr;
    if (!ERR_ON_MISALIGN) begin
      if (size == SZ_H) addr_al[0]   = 1'b0;
      if (size == SZ_W) addr_al[1:0] = 2'b00;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= addr_al;
            we_q    <= we;
            size_q  <= size;
            uns_q   <= ld_unsigned;
            wdata_q <= wdata;
            if (reject)                  state <= ERR;
            else if (we && size == SZ_W) state <= WR;
            else                         state <= RD;
          end
        end
        RD: begin
          if (!we_q) begin
            word_q <= mem_read_data;
            rdata  <= lane_extract(mem_read_data, addr_q[1:0], size_q, uns_q);
            state  <= DONE;
          end else begin
            word_q <= lane_merge(mem_read_data, addr_q[1:0], size_q, wdata_q);
            state  <= WR;
          end
        end
        WR:      state <= DONE;
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign mem_read    = (state == RD);
  assign mem_write   = (state == WR);
  assign done        = (state == DONE) | (state == ERR);
  assign err         = (state == ERR);
  assign mem_address = {2'b00, addr_q[ADDR_W-1:2]};

  // Word stores write the captured data directly; sub-word stores write the
  // merged word built during RD.
  always_comb begin
    mem_write_data = '0;
    if (state == WR) mem_write_data = (size_q == SZ_W) ? wdata_q : word_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clock;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        ld_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] dmem    [0:63];
  logic [31:0] ref_mem [0:63];
  logic [31:0] ref_rdata;

  mem_access_unit #(.ADDR_W(32), .ERR_ON_MISALIGN(1'b1)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .size(size),
    .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata), .busy(busy),
    .done(done), .err(err), .rdata(rdata), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_write(mem_write),
    .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  assign mem_read_data = dmem[mem_address[5:0]];
  always @(posedge clock) if (mem_write) dmem[mem_address[5:0]] <= mem_write_data;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        e;
    int          n;
  } vec_t;

  vec_t tbl [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: access outcome computed from the lane/extension rules.
  task automatic model(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic e, output int n, output int nrd, output int nwr);
    longint unsigned mask, v, cur;
    int idx, sh, bits;
    bit mis;
    mis = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    e = 1'b0; n = 0; nrd = 0; nwr = 0;
    if (mis) begin
      e = 1'b1; n = 1;
    end else begin
      idx  = int'(a[7:2]);
      sh   = int'(a[1:0]) * 8;
      bits = 8 << sz;
      mask = (64'd1 << bits) - 64'd1;
      cur  = 64'(ref_mem[idx]);
      if (!w) begin
        v = (cur >> sh) & mask;
        if (!u && sz != 2'd2 && v >= (mask + 64'd1) / 64'd2)
          v = v | (~mask & 64'hFFFF_FFFF);
        ref_rdata = v[31:0];
        n = 2; nrd = 1;
      end else begin
        v = (cur & ~(mask << sh)) | ((64'(wd) & mask) << sh);
        ref_mem[idx] = v[31:0];
        nwr = 1;
        if (sz == 2'd2) n = 2;
        else begin n = 3; nrd = 1; end
      end
    end
  endtask

  // Drives one access from IDLE and observes it until done (bounded).
  task automatic run_access(input logic w, input logic [1:0] sz, input logic u,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] g_rd, output logic g_err,
                            output int g_n, output int g_nrd, output int g_nwr);
    we = w; size = sz; ld_unsigned = u; addr = a; wdata = wd; req = 1'b1;
    @(posedge clock); #1;
    req = 1'b0;
    g_n = 1; g_nrd = 0; g_nwr = 0;
    forever begin
      if (mem_read)  g_nrd++;
      if (mem_write) g_nwr++;
      if (mem_read || mem_write) check("mem_address", mem_address, {2'b00, a[31:2]});
      if (done || g_n >= 8) break;
      @(posedge clock); #1;
      g_n++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
    g_err = err;
    g_rd  = rdata;
    @(posedge clock); #1;
    check("idle_after", 32'(busy), 32'd0);
  endtask

  task automatic do_op(input string nm, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] g_rd; logic g_err; int g_n, g_nrd, g_nwr;
    logic e; int n, nrd, nwr;
    run_access(w, sz, u, a, wd, g_rd, g_err, g_n, g_nrd, g_nwr);
    model(w, sz, u, a, wd, e, n, nrd, nwr);
    check({nm, "_err"},   32'(g_err), 32'(e));
    check({nm, "_lat"},   32'(g_n),   32'(n));
    check({nm, "_nrd"},   32'(g_nrd), 32'(nrd));
    check({nm, "_nwr"},   32'(g_nwr), 32'(nwr));
    check({nm, "_rdata"}, g_rd,       ref_rdata);
  endtask

  initial begin
    logic [31:0] g_rd; logic g_err; int g_n, g_nrd, g_nwr;
    logic e; int n, nrd, nwr;
    int accepts, dones, last_done;
    logic was_idle;
    logic [31:0] a;

    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    ref_rdata = 32'h0;
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; ld_unsigned = 1'b0;
    addr = 32'h0; wdata = 32'h0;

    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0, 2};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, 32'hDEADBEEF, 1'b0, 2};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 2};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'h00000080, 1'b0, 2};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 32'h12, 32'h0,        32'hFFFFFFFF, 1'b0, 2};
    tbl[6]  = '{1'b0, 2'd0, 1'b0, 32'h10, 32'h0,        32'h00000001, 1'b0, 2};
    tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h11, 32'h0,        32'h00000001, 1'b1, 1};
    tbl[8]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 32'h00000001, 1'b0, 2};
    tbl[9]  = '{1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFFAA, 32'h00000001, 1'b0, 3};
    tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h1122AA44, 1'b0, 2};
    tbl[11] = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h1234BEEF, 32'h1122AA44, 1'b0, 3};
    tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hBEEFAA44, 1'b0, 2};
    tbl[13] = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'h0000BEEF, 1'b0, 2};
    tbl[14] = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        32'hFFFFBEEF, 1'b0, 2};
    tbl[15] = '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        32'hFFFFAA44, 1'b0, 2};
    tbl[16] = '{1'b0, 2'd1, 1'b1, 32'h10, 32'h0,        32'h0000AA44, 1'b0, 2};
    tbl[17] = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'h0000AA44, 1'b1, 1};
    tbl[18] = '{1'b1, 2'd2, 1'b0, 32'h12, 32'h0,        32'h0000AA44, 1'b1, 1};
    tbl[19] = '{1'b0, 2'd2, 1'b0, 32'h11, 32'h0,        32'h0000AA44, 1'b1, 1};
    tbl[20] = '{1'b0, 2'd0, 1'b0, 32'h11, 32'h0,        32'hFFFFFFAA, 1'b0, 2};
    tbl[21] = '{1'b1, 2'd0, 1'b0, 32'h13, 32'h0000007F, 32'hFFFFFFAA, 1'b0, 3};
    tbl[22] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h7FEFAA44, 1'b0, 2};

    repeat (2) @(posedge clock);
    #1;
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_err",   32'(err),       32'd0);
    check("rst_rdata", rdata,          32'd0);
    check("rst_mrd",   32'(mem_read),  32'd0);
    check("rst_mwr",   32'(mem_write), 32'd0);
    check("rst_maddr", mem_address,    32'd0);
    check("rst_mwd",   mem_write_data, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Directed table
    for (int i = 0; i < 23; i++) begin
      run_access(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, g_rd, g_err, g_n, g_nrd, g_nwr);
      model(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, e, n, nrd, nwr);
      check($sformatf("tbl%0d_rdata", i), g_rd,        tbl[i].rd);
      check($sformatf("tbl%0d_err", i),   32'(g_err),  32'(tbl[i].e));
      check($sformatf("tbl%0d_lat", i),   32'(g_n),    32'(tbl[i].n));
      check($sformatf("tbl%0d_nrd", i),   32'(g_nrd),  32'(nrd));
      check($sformatf("tbl%0d_nwr", i),   32'(g_nwr),  32'(nwr));
    end
    check("tbl_word4", dmem[4], 32'h7FEFAA44);

    // Reset in the middle of a load's RD cycle
    we = 1'b0; size = 2'd2; ld_unsigned = 1'b0; addr = 32'h10; req = 1'b1;
    @(posedge clock); #1;
    req = 1'b0;
    check("mid_rd_mread", 32'(mem_read), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy",  32'(busy),     32'd0);
    check("abort_mread", 32'(mem_read), 32'd0);
    check("abort_done",  32'(done),     32'd0);
    check("abort_rdata", rdata,         32'd0);
    check("abort_maddr", mem_address,   32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    ref_rdata = 32'h0;
    @(posedge clock); #1;
    do_op("post_rst_lw", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("post_rst_val", ref_rdata, 32'h7FEFAA44);

    // Fill memory with random words
    for (int i = 0; i < 64; i++) do_op("fill", 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom);

    // req held high: four loads to consecutive words
    we = 1'b0; size = 2'd2; ld_unsigned = 1'b0; addr = 32'h20; req = 1'b1;
    accepts = 0; dones = 0; last_done = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      was_idle = !busy;
      @(posedge clock); #1;
      if (was_idle && req) begin
        accepts++;
        addr = addr + 32'd4;
        if (accepts == 4) req = 1'b0;
      end
      if (done) begin
        check($sformatf("b2b_rdata%0d", dones), rdata, ref_mem[8 + dones]);
        if (last_done >= 0) check("b2b_spacing", 32'(cyc - last_done), 32'd3);
        last_done = cyc;
        dones++;
      end
    end
    check("b2b_accepts", 32'(accepts), 32'd4);
    check("b2b_dones",   32'(dones),   32'd4);
    ref_rdata = ref_mem[11];

    // A store request pulsed while busy must be dropped
    we = 1'b0; size = 2'd2; addr = 32'h40; req = 1'b1;
    @(posedge clock); #1;
    we = 1'b1; addr = 32'h44; wdata = ~ref_mem[17];
    @(posedge clock); #1;
    req = 1'b0;
    check("drop_done", 32'(done), 32'd1);
    dones = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(posedge clock); #1;
      if (busy || done || mem_write) dones++;
    end
    check("drop_activity", 32'(dones), 32'd0);
    check("drop_word17",   dmem[17],   ref_mem[17]);
    check("drop_rdata",    rdata,      ref_mem[16]);
    ref_rdata = ref_mem[16];

    // Randomized accesses against the reference model
    for (int i = 0; i < 150; i++) begin
      a = 32'($urandom_range(0, 255));
      do_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), a, $urandom);
    end

    for (int i = 0; i < 64; i++) check($sformatf("mem%0d", i), dmem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
